// File: rtl/ste_disp_pkg.sv
// Shared types and constants for the RMS-to-BCD display path.
package ste_disp_pkg;

  localparam int BCD_NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } t_bcd_state;

  // 10^n, used for the saturation limit and the binary width
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/ste_bin2bcd_dd.sv
// Iterative double-dabble core: one add-3/shift step per clock after start.
module ste_bin2bcd_dd
  import ste_disp_pkg::*;
#(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [BIN_W-1:0]               bin,
  output logic                           done,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BCD_W-1:0] bcd_r;
  logic [BCD_W-1:0] adj;
  logic [BIN_W-1:0] bin_r;
  logic [CNT_W-1:0] cnt;
  logic             active;

  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] >= 4'd5)
        adj[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] = bcd_r[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] + 4'd3;
    end
  end

  // done marks the cycle whose edge performs the final shift
  assign done = active && (cnt == CNT_W'(1));
  assign bcd  = bcd_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_r  <= '0;
      bin_r  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      bcd_r  <= '0;
      bin_r  <= bin;
      cnt    <= CNT_W'(BIN_W);
      active <= 1'b1;
    end else if (active) begin
      bcd_r <= {adj[BCD_W-2:0], bin_r[BIN_W-1]};
      bin_r <= {bin_r[BIN_W-2:0], 1'b0};
      cnt   <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/ste_rms_to_bcd.sv
// Scales the RMS code to millivolts, saturates, and converts it to packed BCD.
module ste_rms_to_bcd
  import ste_disp_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SCALE_NUM   = 1000,
  parameter int SCALE_SHIFT = 16,
  parameter int DIGITS      = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              din_i,
  input  logic                           din_update_i,
  input  logic                           clr_i,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_o,
  output logic                           ovf_o,
  output logic                           busy_o,
  output logic                           dout_update_o
);

  localparam int PROD_W  = DATA_W + $clog2(SCALE_NUM + 1);
  localparam int MAX_VAL = pow10(DIGITS) - 1;
  localparam int BIN_W   = $clog2(pow10(DIGITS));
  localparam int BCD_W   = BCD_NIBBLE_W * DIGITS;
  localparam int CMP_W   = (PROD_W > 32) ? PROD_W : 32;

  t_bcd_state        state, state_nxt;
  logic [DATA_W-1:0] sample;
  logic              pending;
  logic              ovf_hold;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] scaled;
  logic              over;
  logic [BIN_W-1:0]  bin_sat;
  logic              kill;
  logic              core_start;
  logic              core_done;
  logic [BCD_W-1:0]  core_bcd;

  assign kill    = rst | clr_i;
  assign prod    = PROD_W'(sample) * PROD_W'(SCALE_NUM);
  assign scaled  = prod >> SCALE_SHIFT;
  assign over    = CMP_W'(scaled) > CMP_W'(MAX_VAL);
  assign bin_sat = over ? BIN_W'(MAX_VAL) : BIN_W'(scaled);
  assign busy_o  = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    case (state)
      IDLE:  if (din_update_i) state_nxt = SCALE;
      SCALE: begin
        core_start = 1'b1;
        state_nxt  = SHIFT;
      end
      SHIFT: if (core_done) state_nxt = DONE;
      DONE:  state_nxt = (pending || din_update_i) ? SCALE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // sample always holds the newest strobe; SCALE consumes it on its edge,
  // so a strobe arriving while busy simply replaces any earlier waiting one
  always_ff @(posedge clk) begin
    if (kill) begin
      state         <= IDLE;
      sample        <= '0;
      pending       <= 1'b0;
      ovf_hold      <= 1'b0;
      bcd_o         <= '0;
      ovf_o         <= 1'b0;
      dout_update_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      dout_update_o <= (state == DONE);
      if (din_update_i) sample <= din_i;
      if (state == DONE)
        pending <= 1'b0;
      else if (din_update_i && state != IDLE)
        pending <= 1'b1;
      if (state == SCALE) ovf_hold <= over;
      if (state == DONE) begin
        bcd_o <= core_bcd;
        ovf_o <= ovf_hold;
      end
    end
  end

  ste_bin2bcd_dd #(
    .BIN_W (BIN_W),
    .DIGITS(DIGITS)
  ) u_dd (
    .clk  (clk),
    .rst  (kill),
    .start(core_start),
    .bin  (bin_sat),
    .done (core_done),
    .bcd  (core_bcd)
  );

endmodule
